// File: rtl/sram_responder.sv
// Wait-state responder between the SLC-3 memory handshake and an async SRAM.
// Define SRAM_RESPONDER_IO_MAP_EN to decode address 0xFFFF as the switch/hex I/O word.
module sram_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Mem_Ready,
    output logic [19:0]       SRAM_ADDR,
    input  logic [DATA_W-1:0] SRAM_DQ_in,
    output logic [DATA_W-1:0] SRAM_DQ_out,
    output logic              SRAM_DQ_oe,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    input  logic [15:0]       Switches,
    output logic [15:0]       Hex_reg
);
    typedef enum logic [2:0] {
        IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE, WAIT_REL
    } state_t;

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              ce_n;
    logic              is_io;
    logic [DATA_W-1:0] io_rd;

`ifdef SRAM_RESPONDER_IO_MAP_EN
    logic [15:0] hex_q;

    assign is_io   = (ADDR == ADDR_W'(16'hFFFF));
    assign io_rd   = DATA_W'(Switches);
    assign Hex_reg = hex_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            hex_q <= '0;
        else if (state == IDLE && Mem_WE && is_io)
            hex_q <= 16'(Data_from_CPU);
    end
`else
    logic unused_switches;

    assign is_io           = 1'b0;
    assign io_rd           = '0;
    assign Hex_reg         = 16'h0;
    assign unused_switches = ^Switches;
`endif

    // Chip and byte enables always move together; both bytes are accessed every time.
    assign SRAM_CE_N = ce_n;
    assign SRAM_UB_N = ce_n;
    assign SRAM_LB_N = ce_n;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ce_n        <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            SRAM_DQ_oe  <= 1'b0;
            Mem_Ready   <= 1'b0;
            Data_to_CPU <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
        end else begin
            Mem_Ready <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (Mem_OE || Mem_WE) begin
                        SRAM_ADDR   <= 20'(ADDR);
                        SRAM_DQ_out <= Data_from_CPU;
                        if (is_io) begin
                            // I/O word completes immediately without touching the SRAM pins.
                            state     <= DONE;
                            Mem_Ready <= 1'b1;
                            if (!Mem_WE)
                                Data_to_CPU <= io_rd;
                        end else if (Mem_WE) begin
                            state      <= WR_SETUP;
                            ce_n       <= 1'b0;
                            SRAM_DQ_oe <= 1'b1;
                        end else begin
                            state     <= RD_ACC;
                            ce_n      <= 1'b0;
                            SRAM_OE_N <= 1'b0;
                        end
                    end
                end
                RD_ACC: begin
                    if (cnt == CW'(RD_WAIT - 1)) begin
                        Data_to_CPU <= SRAM_DQ_in;
                        ce_n        <= 1'b1;
                        SRAM_OE_N   <= 1'b1;
                        Mem_Ready   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_SETUP: begin
                    SRAM_WE_N <= 1'b0;
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt == CW'(WR_WAIT - 1)) begin
                        SRAM_WE_N <= 1'b1;
                        state     <= WR_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_HOLD: begin
                    ce_n       <= 1'b1;
                    SRAM_DQ_oe <= 1'b0;
                    Mem_Ready  <= 1'b1;
                    state      <= DONE;
                end
                DONE: state <= WAIT_REL;
                WAIT_REL: begin
                    // Held requests must drop before another access can start.
                    if (!Mem_OE && !Mem_WE)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the SLC-3 datapath. It accepts the level-held `Mem_OE`/`Mem_WE` requests that the control unit issues during its multi-cycle memory states, runs a parameterised wait-state access on the external asynchronous SRAM, and returns read data plus a one-cycle completion strobe. It sits between the MAR/MDR registers and the board SRAM pins, and optionally decodes the memory-mapped switch/hex I/O word.

## Interface
- `ADDR_W`, 16, CPU address width (MAR width)
- `DATA_W`, 16, data width
- `RD_WAIT`, 2, cycles `SRAM_OE_N` is held low before read data is captured (≥1)
- `WR_WAIT`, 2, cycles `SRAM_WE_N` is held low per write (≥1)

Ports:
- `Clk`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset (0 = reset)
- `Mem_OE`  in  1  read request, active-high, held by CPU
- `Mem_WE`  in  1  write request, active-high, held by CPU
- `ADDR`  in  ADDR_W  address from MAR
- `Data_from_CPU`  in  DATA_W  write data from MDR
- `Data_to_CPU`  out  DATA_W  registered read data
- `Mem_Ready`  out  1  one-cycle completion pulse
- `SRAM_ADDR`  out  20  `{4'b0, latched ADDR}`
- `SRAM_DQ_in`  in  DATA_W  data from the pad
- `SRAM_DQ_out`  out  DATA_W  data to the pad
- `SRAM_DQ_oe`  out  1  pad output enable
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  active-low SRAM strobes
- `Switches`  in  16  board switches (I/O read source)
- `Hex_reg`  out  16  hex-display register (I/O write target)

## Operation
- States: IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE, WAIT_REL.
- IDLE: if `Mem_WE`=1, go to WR_SETUP. Otherwise, if `Mem_OE`=1, go to RD_ACC. When both are high, the write wins. On leaving IDLE, latch `ADDR` and `Data_from_CPU`.
- RD_ACC: counter runs from 0 to RD_WAIT-1. On the last cycle, capture `SRAM_DQ_in` into `Data_to_CPU`, then go to DONE.
- WR_SETUP: 1 cycle, then WR_PULSE.
- WR_PULSE: WR_WAIT cycles, then WR_HOLD.
- WR_HOLD: 1 cycle, then DONE.
- DONE: `Mem_Ready`=1 for exactly 1 cycle, then WAIT_REL.
- WAIT_REL: stay until `Mem_OE`=0 and `Mem_WE`=0, then IDLE. A held request therefore produces exactly one access.
- Strobes (all high outside the states listed):
  - `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` low in RD_ACC, WR_SETUP, WR_PULSE and WR_HOLD.
  - `SRAM_OE_N` low only in RD_ACC.
  - `SRAM_WE_N` low only in WR_PULSE.
  - `SRAM_DQ_oe`=1 in WR_SETUP through WR_HOLD.
  - `SRAM_DQ_out` = latched write data.
- `Data_to_CPU` holds its value until the next completed read.
- Requests that change while an access is in progress are ignored. The latched address and data are used for the whole access.

## Timing
- Cycle 0 is the first cycle IDLE sees a request.
- Read: RD_ACC occupies cycles 1..RD_WAIT. `Mem_Ready` and valid `Data_to_CPU` appear in cycle RD_WAIT+1.
- Write:
  - WR_SETUP in cycle 1.
  - `SRAM_WE_N` low in cycles 2..WR_WAIT+1.
  - WR_HOLD in cycle WR_WAIT+2.
  - `Mem_Ready` in cycle WR_WAIT+3.
- Minimum spacing between accesses: one IDLE cycle after the request drops.
- Reset low (asynchronous, any state):
  - State becomes IDLE.
  - All `SRAM_*_N` = 1, `SRAM_DQ_oe` = 0.
  - `Mem_Ready`, `Data_to_CPU`, `SRAM_ADDR`, `SRAM_DQ_out`, `Hex_reg` = 0.
  - An in-flight write is abandoned.

## Configuration
- `SRAM_RESPONDER_IO_MAP_EN` defined:
  - Address 0xFFFF is I/O and raises no SRAM strobe.
  - I/O read: `Data_to_CPU` ← `Switches`, `Mem_Ready` in cycle 1.
  - I/O write: `Hex_reg` ← latched data, `Mem_Ready` in cycle 1.
  - Both then go to WAIT_REL.
- Undefined: 0xFFFF is an ordinary SRAM address and `Hex_reg` is constant 0.

## Test plan
- Read with RD_WAIT=2, `ADDR`=0x0010, SRAM model holding 0x1234 → `SRAM_OE_N` low in cycles 1–2, `Mem_Ready` in cycle 3, `Data_to_CPU`=0x1234.
- Write of 0xBEEF to 0x0020 with WR_WAIT=2 → `SRAM_WE_N` low in cycles 2–3, `SRAM_DQ_oe` high in cycles 1–4, `Mem_Ready` in cycle 5; a following read of 0x0020 returns 0xBEEF.
- `Mem_OE` held for 10 cycles → exactly one `Mem_Ready` pulse and one `SRAM_OE_N` window; a second access starts only after `Mem_OE` drops and rises again.
- `Mem_OE`=`Mem_WE`=1 at 0x0030 with data 0x5555 → write sequence runs, no `SRAM_OE_N` assertion, memory[0x0030]=0x5555.
- With the macro defined:
  - `Switches`=0x00A5 and a read of 0xFFFF → `Data_to_CPU`=0x00A5 in cycle 1, all SRAM strobes stay high.
  - A write of 0x0F0F to 0xFFFF → `Hex_reg`=0x0F0F.
- `Reset` driven low in cycle 2 of a write → `SRAM_WE_N`=1 and `SRAM_DQ_oe`=0 immediately, no `Mem_Ready`, state IDLE after `Reset` releases.
